// File: rtl/mips_cpu_fetch.sv
// Instruction fetch unit for a MIPS-style pipeline front end.
// Fetches one word per instruction and hands it to the decoder, then waits for
// the decoder to accept it. On accept it picks the next PC. Taken branches and
// jumps are applied after their delay slot.
//
//   state   | meaning
//   FETCH   | read strobe high, address = PC, waiting for waitrequest low
//   HOLD    | Instr/InstrPC valid, waiting for InstrReady
//   HALT    | jumped to address 0, idle until reset
//   FAULT   | branch in delay slot or misaligned target, idle until reset
module mips_cpu_fetch (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic [1:0]  CtrlPC,
  input  logic [31:0] RegTarget,
  output logic        Active,
  output logic        Fault
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] target_q, target_d;
  logic        pending_q, pending_d;
  logic        read_q, valid_q, active_q, fault_q;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] redir;
  logic [31:0] next_pc;

  // Redirect target and next-PC selection, computed from the held instruction.
  always_comb begin
    seq_pc  = instr_pc_q + 32'd4;
    br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    case (CtrlPC)
      2'd1:    redir = seq_pc + br_off;
      2'd2:    redir = {seq_pc[31:28], instr_q[25:0], 2'b00};
      2'd3:    redir = RegTarget;
      default: redir = seq_pc;
    endcase
    // A pending redirect takes effect as the delay slot is accepted.
    next_pc = pending_q ? target_q : seq_pc;
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    target_d   = target_q;
    pending_d  = pending_q;
    case (state_q)
      S_FETCH: begin
        if (!waitrequest) begin
          instr_d    = readdata;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (InstrReady) begin
          pending_d = (CtrlPC != 2'd0);
          if (CtrlPC != 2'd0) target_d = redir;
          if ((pending_q && CtrlPC != 2'd0) || next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else if (next_pc == 32'd0) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_d    = next_pc;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      target_q   <= 32'd0;
      pending_q  <= 1'b0;
      read_q     <= 1'b1;
      valid_q    <= 1'b0;
      active_q   <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      read_q     <= (state_d == S_FETCH);
      valid_q    <= (state_d == S_HOLD);
      active_q   <= (state_d == S_FETCH) || (state_d == S_HOLD);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  // The reset term drops the strobe the moment reset asserts.
  assign read       = read_q & reset_n;
  assign address    = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign Active     = active_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Bench for mips_cpu_fetch: memory/decoder model driven from a program table,
// with a scoreboard of fetched words checked when the DUT presents them.
module tb_mips_cpu_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [1:0]  CtrlPC;
  logic [31:0] RegTarget;
  logic        Active;
  logic        Fault;

  mips_cpu_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .CtrlPC      (CtrlPC),
    .RegTarget   (RegTarget),
    .Active      (Active),
    .Fault       (Fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  ctrl;
    logic [31:0] regt;
    int          waits;
    int          holds;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t prog[$];
  sb_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] ctrl,
                     input logic [31:0] regt, input int waits, input int holds);
    vec_t v;
    v.pc = pc; v.instr = instr; v.ctrl = ctrl; v.regt = regt; v.waits = waits; v.holds = holds;
    prog.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    InstrReady  = 1'b0;
    CtrlPC      = 2'd0;
    RegTarget   = 32'h0;
    sb.delete();
    #1;
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_address", address, 32'hBFC0_0000);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_instrpc", InstrPC, 32'd0);
    chk("rst_active", {31'd0, Active}, 32'd1);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // One instruction per table entry: fetch (with optional stalls), present,
  // optionally hold off the decoder, then accept with the entry's redirect code.
  task automatic serve();
    sb_t e;
    for (int i = 0; i < prog.size(); i++) begin
      chk("fetch_read", {31'd0, read}, 32'd1);
      chk("fetch_addr", address, prog[i].pc);
      for (int w = 0; w < prog[i].waits; w++) begin
        waitrequest = 1'b1;
        readdata    = 32'hDEAD_0000 | w;
        step();
        chk("stall_read", {31'd0, read}, 32'd1);
        chk("stall_addr", address, prog[i].pc);
        chk("stall_valid", {31'd0, InstrValid}, 32'd0);
      end
      waitrequest = 1'b0;
      readdata    = prog[i].instr;
      e.pc = prog[i].pc; e.instr = prog[i].instr;
      sb.push_back(e);
      step();
      waitrequest = 1'b1;
      readdata    = 32'hBAD0_BAD0;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got 0 entries expected 1");
        return;
      end
      for (int h = 0; h < prog[i].holds; h++) begin
        InstrReady = 1'b0;
        CtrlPC     = 2'd3;
        chk("hold_valid", {31'd0, InstrValid}, 32'd1);
        chk("hold_read", {31'd0, read}, 32'd0);
        chk("hold_instr", Instr, sb[0].instr);
        chk("hold_instrpc", InstrPC, sb[0].pc);
        step();
      end
      e = sb.pop_front();
      chk("valid", {31'd0, InstrValid}, 32'd1);
      chk("instr", Instr, e.instr);
      chk("instrpc", InstrPC, e.pc);
      chk("present_read", {31'd0, read}, 32'd0);
      InstrReady = 1'b1;
      CtrlPC     = prog[i].ctrl;
      RegTarget  = prog[i].regt;
      step();
      InstrReady = 1'b0;
      CtrlPC     = 2'd1;
      RegTarget  = 32'h1234_5678;
    end
  endtask

  task automatic check_idle(input logic exp_fault);
    for (int k = 0; k < 3; k++) begin
      chk("idle_active", {31'd0, Active}, 32'd0);
      chk("idle_read", {31'd0, read}, 32'd0);
      chk("idle_valid", {31'd0, InstrValid}, 32'd0);
      chk("idle_fault", {31'd0, Fault}, {31'd0, exp_fault});
      waitrequest = 1'b0;
      readdata    = 32'hFFFF_0000;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    InstrReady  = 1'b0;
    CtrlPC      = 2'd0;
    RegTarget   = 32'h0;

    // Long program: stalls, decoder hold-off, branch back, J, forward branch,
    // JR, and a JR to 0 ending in HALT.
    do_reset();
    prog.delete();
    add(32'hBFC0_0000, 32'h2402_0005, 2'd0, 32'h0,          3, 0);
    add(32'hBFC0_0004, 32'h2402_0005, 2'd0, 32'h0,          0, 0);
    add(32'hBFC0_0008, 32'h2402_0005, 2'd0, 32'h0,          0, 0);
    add(32'hBFC0_000C, 32'h2402_0005, 2'd0, 32'h0,          0, 5);
    add(32'hBFC0_0010, 32'h1000_FFFC, 2'd1, 32'h0,          0, 0);
    add(32'hBFC0_0014, 32'h0000_0000, 2'd0, 32'h0,          1, 0);
    add(32'hBFC0_0004, 32'h0800_0040, 2'd2, 32'h0,          0, 0);
    add(32'hBFC0_0008, 32'h0000_0000, 2'd0, 32'h0,          0, 0);
    add(32'hB000_0100, 32'h1000_000C, 2'd1, 32'h0,          2, 0);
    add(32'hB000_0104, 32'h0000_0000, 2'd0, 32'h0,          0, 1);
    add(32'hB000_0134, 32'h0060_0008, 2'd3, 32'hBFC0_0020, 0, 0);
    add(32'hB000_0138, 32'h0000_0000, 2'd0, 32'h0,          0, 0);
    add(32'hBFC0_0020, 32'h0000_0008, 2'd3, 32'h0000_0000, 0, 0);
    add(32'hBFC0_0024, 32'h0000_0000, 2'd0, 32'h0,          0, 0);
    serve();
    check_idle(1'b0);

    // JR to a misaligned target: FAULT after the delay slot.
    do_reset();
    prog.delete();
    add(32'hBFC0_0000, 32'h0060_0008, 2'd3, 32'h0040_0002, 0, 0);
    add(32'hBFC0_0004, 32'h0000_0000, 2'd0, 32'h0,          0, 0);
    serve();
    check_idle(1'b1);

    // Jump in a delay slot: FAULT.
    do_reset();
    prog.delete();
    add(32'hBFC0_0000, 32'h1000_0004, 2'd1, 32'h0,          0, 0);
    add(32'hBFC0_0004, 32'h0800_0040, 2'd2, 32'h0,          0, 0);
    serve();
    check_idle(1'b1);

    // Reset pulsed during a stalled fetch away from the reset vector.
    do_reset();
    prog.delete();
    add(32'hBFC0_0000, 32'h2402_0005, 2'd0, 32'h0,          0, 0);
    serve();
    chk("mid_addr", address, 32'hBFC0_0004);
    waitrequest = 1'b1;
    step();
    chk("mid_read", {31'd0, read}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'd0, read}, 32'd0);
    chk("mid_rst_addr", address, 32'hBFC0_0000);
    chk("mid_rst_instr", Instr, 32'd0);
    chk("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    sb.delete();
    prog.delete();
    add(32'hBFC0_0000, 32'h3C01_ABCD, 2'd0, 32'h0,          1, 0);
    add(32'hBFC0_0004, 32'h2402_0005, 2'd0, 32'h0,          0, 0);
    serve();
    chk("after_addr", address, 32'hBFC0_0008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
